// File: rtl/l2_bus_pkg.sv
// Bus-op, snoop-result and MESI encodings shared between the L2 and its snoop responder,
// plus the snoop decision rules applied to a single directory lookup.
package l2_bus_pkg;

    typedef enum logic [1:0] {
        OP_READ       = 2'd0,
        OP_WRITE      = 2'd1,
        OP_INVALIDATE = 2'd2,
        OP_RWIM       = 2'd3
    } bus_op_e;

    typedef enum logic [1:0] {
        RES_HIT   = 2'd0,
        RES_HITM  = 2'd1,
        RES_NOHIT = 2'd2
    } snoop_res_e;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2,
        ST_WB     = 2'd3
    } fsm_e;

    localparam int CNT_W = 16;

    typedef struct packed {
        snoop_res_e result;
        mesi_e      next_state;
        logic       err;
    } snoop_dec_t;

    // A WRITE from the L2 to a line we hold, or an INVALIDATE of an exclusive
    // line, means the two caches disagree on ownership: flag it, then drop our copy.
    function automatic snoop_dec_t snoop_decide(bus_op_e op, logic hit, mesi_e st);
        snoop_dec_t d;
        d.result     = RES_NOHIT;
        d.next_state = st;
        d.err        = 1'b0;
        if (hit) begin
            case (op)
                OP_READ: begin
                    d.result     = (st == MESI_M) ? RES_HITM : RES_HIT;
                    d.next_state = MESI_S;
                end
                OP_RWIM: begin
                    d.result     = (st == MESI_M) ? RES_HITM : RES_HIT;
                    d.next_state = MESI_I;
                end
                OP_INVALIDATE: begin
                    d.result     = RES_HIT;
                    d.next_state = MESI_I;
                    d.err        = (st != MESI_S);
                end
                default: begin
                    d.result     = RES_NOHIT;
                    d.next_state = MESI_I;
                    d.err        = 1'b1;
                end
            endcase
        end
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/l2_snoop_responder_if.sv
// System-bus bundle between the L2 (master) and the snoop responder (slave).
// Every channel is valid/ready: a transfer happens on a rising edge where both are high;
// a source holds valid and payload stable until that edge and never waits on ready to raise valid.
interface l2_snoop_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_result;

    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;

    logic              fill_valid;
    logic              fill_ready;
    logic [ADDR_W-1:0] fill_addr;
    logic [1:0]        fill_state;

    modport master (
        output req_valid, req_op, req_addr, rsp_ready, wb_ready,
               fill_valid, fill_addr, fill_state,
        input  req_ready, rsp_valid, rsp_result, wb_valid, wb_addr, fill_ready
    );

    modport slave (
        input  req_valid, req_op, req_addr, rsp_ready, wb_ready,
               fill_valid, fill_addr, fill_state,
        output req_ready, rsp_valid, rsp_result, wb_valid, wb_addr, fill_ready
    );
endinterface

// File: rtl/snoop_dir.sv
// Fully associative tag/MESI array: parallel match, lowest free slot and round-robin victim.
// Storage is written only through the single port driven by the parent FSM.
module snoop_dir
    import l2_bus_pkg::*;
#(
    parameter int TAG_W   = 26,
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] look_tag,
    output logic             match,
    output logic [IDX_W-1:0] match_idx,
    output mesi_e            match_state,
    output logic             free_found,
    output logic [IDX_W-1:0] free_idx,
    output logic [IDX_W-1:0] victim_idx,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  mesi_e            wr_state,
    input  logic             rr_adv
);
    logic [TAG_W-1:0] tag_q [ENTRIES];
    mesi_e            st_q  [ENTRIES];
    logic [IDX_W-1:0] rr_q;

    always_comb begin
        match       = 1'b0;
        match_idx   = '0;
        match_state = MESI_I;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!match && st_q[i] != MESI_I && tag_q[i] == look_tag) begin
                match       = 1'b1;
                match_idx   = IDX_W'(i);
                match_state = st_q[i];
            end
            if (!free_found && st_q[i] == MESI_I) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign victim_idx = rr_q;

    // ENTRIES is a power of two, so the pointer wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                st_q[i]  <= MESI_I;
            end
            rr_q <= '0;
        end else begin
            if (wr_en) begin
                tag_q[wr_idx] <= wr_tag;
                st_q[wr_idx]  <= wr_state;
            end
            if (rr_adv) begin
                rr_q <= rr_q + IDX_W'(1);
            end
        end
    end
endmodule

// File: rtl/l2_snoop_responder.sv
// Peer agent on the L2 system bus: answers each bus op with HIT/HITM/NOHIT from a MESI
// directory and pushes out the modified line on HITM. One operation in flight at a time.
module l2_snoop_responder
    import l2_bus_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int ENTRIES  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    l2_snoop_responder_if.slave  bus,
    output logic                 proto_err,
    output logic [CNT_W-1:0]     cnt_hit,
    output logic [CNT_W-1:0]     cnt_hitm,
    output logic [CNT_W-1:0]     cnt_nohit,
    output fsm_e                 dbg_state
);
    localparam int TAG_W = ADDR_W - OFFSET_W;
    localparam int IDX_W = $clog2(ENTRIES);

    fsm_e              state_q, state_d;
    bus_op_e           op_q;
    logic [TAG_W-1:0]  tag_q;
    logic [TAG_W-1:0]  look_tag;
    logic              rsp_valid_q;
    snoop_res_e        rsp_result_q;
    logic              wb_valid_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic              accept;
    logic              fill_take;
    snoop_dec_t        dec;
    mesi_e             fill_st;

    logic              dir_match;
    logic [IDX_W-1:0]  dir_match_idx;
    mesi_e             dir_match_state;
    logic              dir_free_found;
    logic [IDX_W-1:0]  dir_free_idx;
    logic [IDX_W-1:0]  dir_victim_idx;
    logic              dir_wr_en;
    logic [IDX_W-1:0]  dir_wr_idx;
    mesi_e             dir_wr_state;
    logic              dir_rr_adv;

    logic              unused_offsets;
    assign unused_offsets = ^{bus.req_addr[OFFSET_W-1:0], bus.fill_addr[OFFSET_W-1:0]};

    // The directory's single match port serves fills while idle and the latched request otherwise.
    assign look_tag = (state_q == ST_IDLE) ? bus.fill_addr[ADDR_W-1:OFFSET_W] : tag_q;
    assign fill_st  = mesi_e'(bus.fill_state);
    assign dec      = snoop_decide(op_q, dir_match, dir_match_state);

    snoop_dir #(
        .TAG_W   (TAG_W),
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_dir (
        .clk         (clk),
        .rst         (rst),
        .look_tag    (look_tag),
        .match       (dir_match),
        .match_idx   (dir_match_idx),
        .match_state (dir_match_state),
        .free_found  (dir_free_found),
        .free_idx    (dir_free_idx),
        .victim_idx  (dir_victim_idx),
        .wr_en       (dir_wr_en),
        .wr_idx      (dir_wr_idx),
        .wr_tag      (look_tag),
        .wr_state    (dir_wr_state),
        .rr_adv      (dir_rr_adv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        fill_take    = 1'b0;
        dir_wr_en    = 1'b0;
        dir_wr_idx   = dir_match_idx;
        dir_wr_state = MESI_I;
        dir_rr_adv   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = ST_LOOKUP;
                end else if (bus.fill_valid) begin
                    fill_take    = 1'b1;
                    dir_wr_state = fill_st;
                    if (dir_match) begin
                        dir_wr_en = 1'b1;
                    end else if (fill_st != MESI_I) begin
                        dir_wr_en  = 1'b1;
                        dir_wr_idx = dir_free_found ? dir_free_idx : dir_victim_idx;
                        dir_rr_adv = !dir_free_found;
                    end
                end
            end
            ST_LOOKUP: begin
                state_d      = ST_RESP;
                dir_wr_en    = dir_match;
                dir_wr_state = dec.next_state;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = (rsp_result_q == RES_HITM) ? ST_WB : ST_IDLE;
                end
            end
            ST_WB: begin
                if (bus.wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= OP_READ;
            tag_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= RES_NOHIT;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            proto_err    <= 1'b0;
            cnt_hit      <= '0;
            cnt_hitm     <= '0;
            cnt_nohit    <= '0;
        end else begin
            if (accept) begin
                op_q  <= bus_op_e'(bus.req_op);
                tag_q <= bus.req_addr[ADDR_W-1:OFFSET_W];
            end
            if (state_q == ST_LOOKUP) begin
                rsp_valid_q  <= 1'b1;
                rsp_result_q <= dec.result;
                wb_addr_q    <= {tag_q, {OFFSET_W{1'b0}}};
                if (dec.err) begin
                    proto_err <= 1'b1;
                end
                case (dec.result)
                    RES_HIT:  cnt_hit   <= sat_inc(cnt_hit);
                    RES_HITM: cnt_hitm  <= sat_inc(cnt_hitm);
                    default:  cnt_nohit <= sat_inc(cnt_nohit);
                endcase
            end
            if (state_q == ST_RESP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
                if (rsp_result_q == RES_HITM) begin
                    wb_valid_q <= 1'b1;
                end
            end
            if (state_q == ST_WB && bus.wb_ready) begin
                wb_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.fill_ready = fill_take & ~rst;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_addr    = wb_addr_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_l2_snoop_responder.sv
// Bench for l2_snoop_responder: directed scenarios then randomized ops against a line-level
// MESI reference model; expected results queue up at issue and are popped by a bus monitor.
module tb_l2_snoop_responder;
    import l2_bus_pkg::*;

    logic clk;
    logic rst;
    logic proto_err;
    logic [15:0] cnt_hit, cnt_hitm, cnt_nohit;
    fsm_e dbg_state;

    l2_snoop_responder_if #(.ADDR_W(32)) bus();

    l2_snoop_responder #(
        .ADDR_W   (32),
        .OFFSET_W (6),
        .ENTRIES  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .proto_err (proto_err),
        .cnt_hit   (cnt_hit),
        .cnt_hitm  (cnt_hitm),
        .cnt_nohit (cnt_nohit),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    bit rnd_mode = 1'b0;
    bit wb_hold  = 1'b0;

    logic [1:0]  exp_q[$];
    logic [31:0] wb_exp_q[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model (line granularity) ----------------
    int unsigned m_line[8];
    int          m_st[8];
    int          m_rr;
    int          m_hit, m_hitm, m_nohit;
    bit          m_err;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_line[i] = 0;
            m_st[i]   = 0;
        end
        m_rr = 0; m_hit = 0; m_hitm = 0; m_nohit = 0; m_err = 1'b0;
    endfunction

    function automatic int model_find(input int unsigned line);
        for (int i = 0; i < 8; i++)
            if (m_st[i] != 0 && m_line[i] == line) return i;
        return -1;
    endfunction

    function automatic void model_fill(input logic [31:0] a, input int st);
        int unsigned line = a >> 6;
        int i = model_find(line);
        if (i >= 0) begin
            m_st[i] = st;
            return;
        end
        if (st == 0) return;
        for (int j = 0; j < 8; j++) begin
            if (m_st[j] == 0) begin
                m_line[j] = line; m_st[j] = st;
                return;
            end
        end
        m_line[m_rr] = line; m_st[m_rr] = st;
        m_rr = (m_rr + 1) % 8;
    endfunction

    // Spec table: READ/RWIM give HITM on M (with writeback), HIT on S/E; INVALIDATE hits S
    // (E/M is a protocol error); WRITE to a held line is an error returning NOHIT.
    function automatic logic [1:0] model_req(input int op, input logic [31:0] a);
        int unsigned line = a >> 6;
        int i = model_find(line);
        int res = 2;
        if (i >= 0) begin
            int s = m_st[i];
            case (op)
                0: begin res = (s == 3) ? 1 : 0; m_st[i] = 1; end
                3: begin res = (s == 3) ? 1 : 0; m_st[i] = 0; end
                2: begin res = 0; if (s != 1) m_err = 1'b1; m_st[i] = 0; end
                default: begin res = 2; m_err = 1'b1; m_st[i] = 0; end
            endcase
            if (res == 1) wb_exp_q.push_back(line << 6);
        end
        if (res == 0) m_hit++;
        else if (res == 1) m_hitm++;
        else m_nohit++;
        exp_q.push_back(2'(res));
        return 2'(res);
    endfunction

    // ---------------- ready drivers ----------------
    initial begin
        bus.rsp_ready = 1'b1;
        bus.wb_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.wb_ready  = wb_hold ? 1'b0 : (rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 32'(bus.rsp_result), 32'hFFFF_FFFF);
                else check("rsp_result", 32'(bus.rsp_result), 32'(exp_q.pop_front()));
            end
            if (bus.wb_valid && bus.wb_ready) begin
                if (wb_exp_q.size() == 0) check("wb_unexpected", bus.wb_addr, 32'hFFFF_FFFF);
                else check("wb_addr", bus.wb_addr, wb_exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.fill_valid = 1'b1;
        bus.fill_addr  = 32'h0000_7000;
        bus.fill_state = 2'd1;
        exp_q.delete();
        wb_exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_wb_valid", 32'(bus.wb_valid), 0);
        check("rst_fill_ready", 32'(bus.fill_ready), 0);
        check("rst_proto_err", 32'(proto_err), 0);
        check("rst_rsp_result", 32'(bus.rsp_result), 2);
        check("rst_wb_addr", bus.wb_addr, 0);
        check("rst_counters", {cnt_hit, cnt_hitm} | 32'(cnt_nohit), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        bus.fill_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(bus.req_ready), 1);
    endtask

    task automatic do_fill(input logic [31:0] a, input logic [1:0] st);
        int n;
        @(negedge clk);
        bus.fill_valid = 1'b1;
        bus.fill_addr  = a;
        bus.fill_state = st;
        #1;
        n = 0;
        while (!bus.fill_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.fill_ready) begin
            check("fill_ready_timeout", 32'(bus.fill_ready), 1);
            bus.fill_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.fill_valid = 1'b0;
        model_fill(a, int'(st));
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input bit wait_done,
                          input bit with_fill, input logic [31:0] f_addr, input logic [1:0] f_st);
        int n;
        logic [1:0] r;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("req_ready_timeout", 32'(bus.req_ready), 1);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        if (with_fill) begin
            bus.fill_valid = 1'b1;
            bus.fill_addr  = f_addr;
            bus.fill_state = f_st;
        end
        r = model_req(int'(op), addr);
        #1;
        if (with_fill) check("fill_ready_vs_req", 32'(bus.fill_ready), 0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1_rsp_valid", 32'(bus.rsp_valid), 0);
        check("busy_req_ready", 32'(bus.req_ready), 0);
        @(negedge clk);
        check("lat_cycle2_rsp_valid", 32'(bus.rsp_valid), 1);
        if (!rnd_mode && r == 2'd1) begin
            @(negedge clk);
            check("wb_after_rsp", 32'(bus.wb_valid), 1);
        end else if (!rnd_mode) begin
            @(negedge clk);
            check("idle_cycle3", 32'(bus.req_ready), 1);
        end
        if (!wait_done) return;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("op_done", 32'(bus.req_ready), 1);
        if (with_fill) begin
            check("fill_after_req", 32'(bus.fill_ready), 1);
            @(posedge clk);
            #1;
            bus.fill_valid = 1'b0;
            model_fill(f_addr, int'(f_st));
        end
        check("cnt_hit", 32'(cnt_hit), 32'(m_hit > 65535 ? 65535 : m_hit));
        check("cnt_hitm", 32'(cnt_hitm), 32'(m_hitm > 65535 ? 65535 : m_hitm));
        check("cnt_nohit", 32'(cnt_nohit), 32'(m_nohit > 65535 ? 65535 : m_nohit));
        check("proto_err", 32'(proto_err), 32'(m_err));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'd0;
        bus.req_addr   = '0;
        bus.fill_valid = 1'b0;
        bus.fill_addr  = '0;
        bus.fill_state = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        apply_reset();

        // Modified line: HITM, writeback of the line address, then the entry is S.
        do_fill(32'h0000_1040, 2'd3);
        do_req(2'd0, 32'h0000_1044, 1, 0, 0, 0);
        do_req(2'd0, 32'h0000_1040, 1, 0, 0, 0);

        // Shared line invalidated cleanly.
        do_fill(32'h0000_2000, 2'd1);
        do_req(2'd2, 32'h0000_2000, 1, 0, 0, 0);
        do_req(2'd0, 32'h0000_2000, 1, 0, 0, 0);

        // WRITE to an exclusive line is a protocol error that sticks.
        do_fill(32'h0000_3000, 2'd2);
        do_req(2'd1, 32'h0000_3000, 1, 0, 0, 0);
        do_req(2'd0, 32'h0000_3000, 1, 0, 0, 0);

        // Nine fills into eight entries: the ninth evicts slot 0.
        apply_reset();
        for (int i = 0; i < 9; i++) do_fill(32'h0001_0000 + 32'(i * 64), 2'd1);
        do_req(2'd0, 32'h0001_0000, 1, 0, 0, 0);
        do_req(2'd0, 32'h0001_0200, 1, 0, 0, 0);

        // Request beats a simultaneous fill; the fill lands on the next idle cycle.
        do_req(2'd0, 32'h0000_5000, 1, 1, 32'h0000_5000, 2'd2);
        do_req(2'd0, 32'h0000_5000, 1, 0, 0, 0);

        // Stalled writeback, then reset mid-operation.
        do_fill(32'h0000_6000, 2'd3);
        wb_hold = 1'b1;
        do_req(2'd3, 32'h0000_6000, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("wb_held", 32'(bus.wb_valid), 1);
            check("wb_req_ready_low", 32'(bus.req_ready), 0);
        end
        apply_reset();
        wb_hold = 1'b0;
        do_req(2'd0, 32'h0000_6000, 1, 0, 0, 0);

        // Randomized traffic over twelve lines competing for eight entries.
        rnd_mode = 1'b1;
        for (int t = 0; t < 250; t++) begin
            a = 32'h0004_0000 + 32'($urandom_range(0, 11) * 64);
            if ($urandom_range(0, 9) < 4)
                do_fill(a, 2'($urandom_range(0, 3)));
            else
                do_req(2'($urandom_range(0, 3)), a | 32'($urandom_range(0, 63)), 1, 0, 0, 0);
        end
        rnd_mode = 1'b0;
        repeat (4) @(negedge clk);

        check("rsp_queue_drained", 32'(exp_q.size()), 0);
        check("wb_queue_drained", 32'(wb_exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
